// File: rtl/invert_sq_root.sv
// invert_sq_root: six-stage float32 fast inverse square root,
// magic-constant seed followed by one Newton-Raphson step.
module invert_sq_root #(
    parameter logic [31:0] MAGIC   = 32'h5F3759DF,
    parameter int          LATENCY = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        DataValid
);

    // Wide signed exponent keeps intermediate tiny values exact.
    typedef struct packed {
        logic               z;
        logic               s;
        logic signed [11:0] e;
        logic [23:0]        m;
    } fp_t;

    function automatic fp_t unpack(input logic [31:0] b);
        fp_t r;
        r.z = (b[30:23] == 8'd0);
        r.s = b[31];
        r.e = signed'({4'd0, b[30:23]});
        r.m = {1'b1, b[22:0]};
        return r;
    endfunction

    function automatic logic [4:0] lzc(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 27; i++)
            if (v[i]) n = 5'(26 - i);
        return n;
    endfunction

    // Rounds at float32 subnormal precision when the exponent underflows.
    function automatic fp_t fmul(input fp_t a, input fp_t b);
        fp_t                r;
        logic [47:0]        p;
        logic [47:0]        lost;
        logic signed [11:0] e;
        logic [5:0]         sh;
        logic [24:0]        mr;
        logic [4:0]         lz;
        p  = {24'd0, a.m} * {24'd0, b.m};
        e  = a.e + b.e - 12'sd127 + (p[47] ? 12'sd1 : 12'sd0);
        if (!p[47]) p = p << 1;
        sh = 6'd0;
        if (e < 12'sd1)
            sh = (e < -12'sd46) ? 6'd48 : 6'(12'sd1 - e);
        lost = p & ~({48{1'b1}} << sh);
        p    = p >> sh;
        mr   = {1'b0, p[47:24]}
             + 25'(p[23] & ((|p[22:0]) | (|lost) | p[24]));
        if (sh != 6'd0) e = 12'sd1;
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 12'sd1;
        end
        lz  = lzc({mr[23:0], 3'd0});
        r.z = a.z | b.z | (mr[23:0] == 24'd0);
        r.s = a.s ^ b.s;
        r.e = e - signed'({7'd0, lz});
        r.m = mr[23:0] << lz;
        return r;
    endfunction

    // v = 1.5 - u; a negative u is treated as zero.
    function automatic fp_t fsub15(input fp_t u);
        fp_t                r;
        logic [23:0]        um;
        logic               swap;
        logic [11:0]        d;
        logic [4:0]         dc;
        logic [26:0]        bm, sm, lost, df;
        logic signed [11:0] e;
        logic [4:0]         lz;
        logic [24:0]        mr;
        um   = (u.z | u.s) ? 24'd0 : u.m;
        swap = (um != 24'd0) && (u.e > 12'sd127
             || (u.e == 12'sd127 && um > 24'hC00000));
        bm   = swap ? {um, 3'd0} : {24'hC00000, 3'd0};
        sm   = swap ? {24'hC00000, 3'd0} : {um, 3'd0};
        e    = swap ? u.e : 12'sd127;
        d    = swap ? 12'(u.e - 12'sd127) : 12'(12'sd127 - u.e);
        dc   = (d > 12'd26) ? 5'd27 : d[4:0];
        lost = sm & ~({27{1'b1}} << dc);
        sm   = (sm >> dc) | {26'd0, |lost};
        df   = bm - sm;
        r.z  = (df == 27'd0);
        lz   = lzc(df);
        df   = df << lz;
        e    = e - signed'({7'd0, lz});
        mr   = {1'b0, df[26:3]} + 25'(df[2] & ((|df[1:0]) | df[3]));
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 12'sd1;
        end
        r.s = swap;
        r.e = e;
        r.m = mr[23:0];
        return r;
    endfunction

    function automatic logic [31:0] pack(input fp_t a);
        if (a.z || !a.m[23] || a.e < 12'sd1) return 32'd0;
        if (a.e > 12'sd254) return {a.s, 8'hFE, 23'h7FFFFF};
        return {a.s, a.e[7:0], a.m[22:0]};
    endfunction

    fp_t                x_in, y0_in;
    fp_t                s1_xh, s1_y0;
    fp_t                s2_xh, s2_y0, s2_t;
    fp_t                s3_y0, s3_u;
    fp_t                s4_y0, s4_v;
    logic [31:0]        s5_y, out_q;
    logic [LATENCY-1:0] vld;

    always_comb begin
        x_in   = unpack(DataIn);
        x_in.e = x_in.e - 12'sd1;
        y0_in  = unpack(MAGIC - {1'b0, DataIn[31:1]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_xh <= '0;
            s1_y0 <= '0;
            s2_xh <= '0;
            s2_y0 <= '0;
            s2_t  <= '0;
            s3_y0 <= '0;
            s3_u  <= '0;
            s4_y0 <= '0;
            s4_v  <= '0;
            s5_y  <= '0;
            out_q <= '0;
            vld   <= '0;
        end else begin
            s1_xh <= x_in;
            s1_y0 <= y0_in;
            s2_xh <= s1_xh;
            s2_y0 <= s1_y0;
            s2_t  <= fmul(s1_y0, s1_y0);
            s3_y0 <= s2_y0;
            s3_u  <= fmul(s2_xh, s2_t);
            s4_y0 <= s3_y0;
            s4_v  <= fsub15(s3_u);
            s5_y  <= pack(fmul(s4_y0, s4_v));
            out_q <= s5_y;
            vld   <= {vld[LATENCY-2:0], 1'b1};
        end
    end

    assign DataOut   = rst ? 32'd0 : out_q;
    assign DataValid = vld[LATENCY-1] & ~rst;

endmodule

// File: tb/tb_invert_sq_root.sv
// Bench for invert_sq_root: float32 reference model via doubles,
// scoreboard queue, known-value table and reset sequences.
module tb_invert_sq_root;

    localparam int          LAT   = 6;
    localparam logic [31:0] MAGIC = 32'h5F3759DF;
    localparam logic [31:0] ONE   = 32'h3F800000;

    typedef struct {
        logic [31:0] x;
        real         approx;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        real         approx;
        bit          dc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] din = ONE;
    logic [31:0] dout;
    logic        dvalid;

    sb_t q[$];
    int  checks   = 0;
    int  failures = 0;
    int  run      = 0;
    int  outs     = 0;

    invert_sq_root dut (
        .clk      (clk),
        .rst      (rst),
        .DataIn   (din),
        .DataOut  (dout),
        .DataValid(dvalid)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        real sg;
        sg = b[31] ? -1.0 : 1.0;
        if (b[30:23] == 8'd0)
            return sg * real'(int'(b[22:0])) * (2.0 ** (-149.0));
        return $bitstoreal({b[31], 11'({3'd0, b[30:23]}) + 11'd896,
                            b[22:0], 29'd0});
    endfunction

    // Round a double to float32, nearest-even, keeping subnormals.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0]     b;
        longint unsigned mant, keep, rem, half;
        int              ee, sh;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return {b[63], 31'd0};
        ee   = int'(b[62:52]) - 896;
        mant = {11'd0, 1'b1, b[51:0]};
        sh   = (ee >= 1) ? 29 : 30 - ee;
        if (sh > 54) return {b[63], 31'd0};
        keep = mant >> sh;
        rem  = mant & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep = keep + 1;
        if (ee >= 1) keep = keep + (longint'(ee - 1) << 23);
        return {b[63], keep[30:0]};
    endfunction

    function automatic logic [31:0] c_model(input logic [31:0] x);
        logic [31:0] xh, y0, t, u, v;
        xh = r2f(0.5 * f2r(x));
        y0 = MAGIC - (x >> 1);
        t  = r2f(f2r(y0) * f2r(y0));
        u  = r2f(f2r(xh) * f2r(t));
        v  = r2f(1.5 - f2r(u));
        return r2f(f2r(y0) * f2r(v));
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h required %h at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic [31:0] x,
                         input real approx, input bit dc);
        sb_t    e;
        bit     exp_v;
        longint d;
        real    rel;
        rst = r;
        din = x;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            run = 0;
        end else begin
            e.exp    = c_model(x);
            e.approx = approx;
            e.dc     = dc;
            q.push_back(e);
            run++;
        end
        exp_v = (run >= LAT);
        check(dvalid === exp_v, "valid", {31'd0, dvalid}, {31'd0, exp_v});
        if (r) begin
            check(dout === 32'd0, "reset_out", dout, 32'd0);
        end else if (dvalid === 1'b1 && q.size() > 0) begin
            e = q.pop_front();
            outs++;
            if (!e.dc) begin
                d = longint'(dout) - longint'(e.exp);
                if (d < 0) d = -d;
                check(!$isunknown(dout) && d <= 2, "ulp", dout, e.exp);
                rel = (f2r(dout) - e.approx) / e.approx;
                if (rel < 0.0) rel = -rel;
                check(rel < 0.002, "approx", dout, r2f(e.approx));
            end
        end
    endtask

    function automatic logic [31:0] rand_norm();
        logic [31:0] x;
        x[31]    = 1'b0;
        x[30:23] = 8'($urandom_range(254, 1));
        x[22:0]  = 23'($urandom());
        return x;
    endfunction

    initial begin
        vec_t        tbl[13];
        logic [31:0] x;
        int          lows;

        tbl[0]  = '{32'h3F800000, 1.0};
        tbl[1]  = '{32'h40800000, 0.5};
        tbl[2]  = '{32'h3E800000, 2.0};
        tbl[3]  = '{32'h00800000, 9.223372036854776e18};
        tbl[4]  = '{32'h7F7FFFFF, 5.421010862427522e-20};
        tbl[5]  = '{32'h40000000, 0.7071067811865476};
        tbl[6]  = '{32'h42C80000, 0.1};
        tbl[7]  = '{32'h00000000, 0.0};
        tbl[8]  = '{32'h40400000, 0.5773502691896258};
        tbl[9]  = '{32'hBF800000, 0.0};
        tbl[10] = '{32'h7FC00000, 0.0};
        tbl[11] = '{32'h00000001, 0.0};
        tbl[12] = '{32'h3F800000, 1.0};

        // Power-up with rst never asserted.
        #1;
        check(dvalid === 1'b0, "powerup_valid", {31'd0, dvalid}, 32'd0);
        for (int i = 0; i < 10; i++) cycle(1'b0, ONE, 1.0, 1'b0);

        // Three-cycle reset, then constant 1.0.
        for (int i = 0; i < 3; i++) cycle(1'b1, ONE, 1.0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, ONE, 1.0, 1'b0);

        // Known values, extremes and don't-care specials back to back.
        foreach (tbl[i])
            cycle(1'b0, tbl[i].x, tbl[i].approx, tbl[i].approx == 0.0);
        for (int i = 0; i < LAT; i++) cycle(1'b0, ONE, 1.0, 1'b0);

        // Streaming random normals.
        for (int i = 0; i < 1000; i++) begin
            x = rand_norm();
            cycle(1'b0, x, 1.0 / $sqrt(f2r(x)), 1'b0);
        end
        check(q.size() == LAT - 1, "in_flight",
              32'(q.size()), 32'(LAT - 1));

        // One-cycle reset pulse mid-stream.
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            x = rand_norm();
            cycle(i == 20, x, 1.0 / $sqrt(f2r(x)), 1'b0);
            if (i >= 20 && dvalid === 1'b0) lows++;
        end
        check(lows == LAT, "reset_gap", 32'(lows), 32'(LAT));

        for (int i = 0; i < LAT; i++) cycle(1'b0, ONE, 1.0, 1'b0);
        check(outs > 1000, "out_count", 32'(outs), 32'd1001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
